// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the priority encoder family.
package encoder_pkg;

  localparam int ENC_NONE = 0;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/encoder_x4_prio_cell.sv
// Two-input priority merge node: the high half wins whenever it is valid,
// and its validity becomes the new MSB of the merged index.
module prio_cell #(
  parameter  int IW = 0,
  localparam int PW = (IW > 0) ? IW : 1
) (
  input  logic          vld_hi,
  input  logic [PW-1:0] idx_hi,
  input  logic          vld_lo,
  input  logic [PW-1:0] idx_lo,
  output logic          vld_o,
  output logic [IW:0]   idx_o
);

  assign vld_o = vld_hi | vld_lo;

  generate
    if (IW == 0) begin : g_leaf
      // Leaf inputs carry no index bits; the ports exist only for uniformity.
      wire unused_idx = ^{idx_hi, idx_lo};
      assign idx_o = vld_hi;
    end else begin : g_node
      assign idx_o = {vld_hi, (vld_hi ? idx_hi : idx_lo)};
    end
  endgenerate

endmodule

// File: rtl/encoder_x4.sv
// Registered N-to-log2(N) priority encoder built from a binary tree of
// prio_cell merge nodes, followed by a single output register stage.
module encoder_x4
  import encoder_pkg::*;
#(
  parameter int N = 4,
  parameter int W = clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] x,
  output logic [W-1:0] z,
  output logic         y
);

  logic [W-1:0] z_d, z_q;
  logic         y_d, y_q;

  // Level gi holds N>>gi nodes, each with a gi-bit index.
  generate
    for (genvar gi = 1; gi <= W; gi++) begin : lvl
      localparam int NN = N >> gi;
      localparam int PW = (gi > 1) ? (gi - 1) : 1;
      logic [NN-1:0]         vld;
      logic [NN-1:0][gi-1:0] idx;

      for (genvar gj = 0; gj < NN; gj++) begin : node
        logic          in_vld_hi, in_vld_lo;
        logic [PW-1:0] in_idx_hi, in_idx_lo;

        if (gi == 1) begin : g_from_x
          assign in_vld_hi = x[2*gj+1];
          assign in_vld_lo = x[2*gj];
          assign in_idx_hi = '0;
          assign in_idx_lo = '0;
        end else begin : g_from_prev
          assign in_vld_hi = lvl[gi-1].vld[2*gj+1];
          assign in_vld_lo = lvl[gi-1].vld[2*gj];
          assign in_idx_hi = lvl[gi-1].idx[2*gj+1];
          assign in_idx_lo = lvl[gi-1].idx[2*gj];
        end

        prio_cell #(.IW(gi - 1)) u_cell (
          .vld_hi (in_vld_hi),
          .idx_hi (in_idx_hi),
          .vld_lo (in_vld_lo),
          .idx_lo (in_idx_lo),
          .vld_o  (vld[gj]),
          .idx_o  (idx[gj])
        );
      end
    end
  endgenerate

  always_comb begin
    y_d = lvl[W].vld[0];
    z_d = y_d ? lvl[W].idx[0] : W'(ENC_NONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z_q <= W'(ENC_NONE);
      y_q <= 1'b0;
    end else begin
      z_q <= z_d;
      y_q <= y_d;
    end
  end

  assign z = z_q;
  assign y = y_q;

endmodule

// File: tb/tb_encoder_x4.sv
// Directed and exhaustive checks of the registered 4-to-2 priority encoder.
module tb_encoder_x4;

  logic       clk;
  logic       rst;
  logic [3:0] x;
  logic [1:0] z;
  logic       y;

  int checks;
  int errors;

  encoder_x4 #(.N(4)) dut (
    .clk (clk),
    .rst (rst),
    .x   (x),
    .z   (z),
    .y   (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: scan from the top bit down.
  function automatic logic [1:0] ref_z(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int b = 3; b >= 0; b--) begin
      if (v[b]) begin
        r = 2'(b);
        break;
      end
    end
    return r;
  endfunction

  // Apply one input vector, clock it in, and settle just after the edge.
  task automatic drive(input logic [3:0] xv, input logic rv);
    @(negedge clk);
    x   = xv;
    rst = rv;
    @(posedge clk);
    #1;
    $display("txn rst=%b x=%b -> z=%b y=%b", rv, xv, z, y);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(4'b1111, 1'b1);
      checks++;
      if (z !== 2'b00 || y !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: got z=%b y=%b want z=00 y=0", i, z, y);
      end
    end
    drive(4'b0100, 1'b0);
    checks++;
    if (z !== 2'b10 || y !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got z=%b y=%b want z=10 y=1", z, y);
    end
  endtask

  task automatic test_onehot();
    logic [3:0] vec [4];
    logic [1:0] exp [4];
    vec = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp = '{2'b00, 2'b01, 2'b10, 2'b11};
    for (int i = 0; i < 4; i++) begin
      drive(vec[i], 1'b0);
      checks++;
      if (z !== exp[i] || y !== 1'b1) begin
        errors++;
        $display("FAIL onehot x=%b: got z=%b y=%b want z=%b y=1", vec[i], z, y, exp[i]);
      end
    end
  endtask

  task automatic test_priority();
    logic [3:0] vec [5];
    logic [1:0] exp [5];
    vec = '{4'b0101, 4'b1010, 4'b1100, 4'b0011, 4'b1111};
    exp = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b11};
    for (int i = 0; i < 5; i++) begin
      drive(vec[i], 1'b0);
      checks++;
      if (z !== exp[i] || y !== 1'b1) begin
        errors++;
        $display("FAIL priority x=%b: got z=%b y=%b want z=%b y=1", vec[i], z, y, exp[i]);
      end
    end
  endtask

  task automatic test_zero();
    drive(4'b1000, 1'b0);
    checks++;
    if (z !== 2'b11 || y !== 1'b1) begin
      errors++;
      $display("FAIL zero_pre: got z=%b y=%b want z=11 y=1", z, y);
    end
    drive(4'b0000, 1'b0);
    checks++;
    if (z !== 2'b00 || y !== 1'b0) begin
      errors++;
      $display("FAIL zero: got z=%b y=%b want z=00 y=0", z, y);
    end
  endtask

  task automatic test_mid_reset();
    logic       rv  [5];
    logic [1:0] ez  [5];
    logic       ey  [5];
    rv = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    ez = '{2'b11, 2'b11, 2'b00, 2'b11, 2'b11};
    ey = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive(4'b1000, rv[i]);
      checks++;
      if (z !== ez[i] || y !== ey[i]) begin
        errors++;
        $display("FAIL mid_reset cyc%0d: got z=%b y=%b want z=%b y=%b", i, z, y, ez[i], ey[i]);
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [3:0] order [16];
    logic [3:0] tmp;
    int         j;
    logic       rv;
    logic [1:0] ez;
    logic       ey;
    for (int i = 0; i < 16; i++) order[i] = 4'(i);
    for (int i = 15; i > 0; i--) begin
      j        = int'($urandom_range(0, i));
      tmp      = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 16; i++) begin
        rv = ($urandom_range(0, 3) == 0);
        ez = rv ? 2'b00 : ref_z(order[i]);
        ey = rv ? 1'b0 : (order[i] != 4'b0000);
        drive(order[i], rv);
        checks++;
        if (z !== ez || y !== ey) begin
          errors++;
          $display("FAIL exhaustive x=%b rst=%b: got z=%b y=%b want z=%b y=%b",
                   order[i], rv, z, y, ez, ey);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    x      = 4'b0000;
    test_reset();
    test_onehot();
    test_priority();
    test_zero();
    test_mid_reset();
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
